// File: rtl/fix_div17_if.sv
// rtl/fix_div17_if.sv - operand/result handshake bundle for the fix_div17 divider
interface fix_div17_if #(
    parameter int DW = 17,
    parameter int TW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_17bit;
    logic [TW-1:0] in_8bit;
    logic          out_valid;
    logic [DW-1:0] out;
    logic          sat;
    logic          div_err;

    modport master (
        output in_valid, in_17bit, in_8bit,
        input  in_ready, out_valid, out, sat, div_err
    );

    modport slave (
        input  in_valid, in_17bit, in_8bit,
        output in_ready, out_valid, out, sat, div_err
    );
endinterface

// File: rtl/fix_div17.sv
// rtl/fix_div17.sv - sequential signed fixed-point divider, sample / Q1.7 factor, one quotient bit per clock
// Optional DIV_ROUND_EN: one extra quotient bit, round half away from zero.
module fix_div17 #(
    parameter int DW   = 17,
    parameter int TW   = 8,
    parameter int FRAC = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    fix_div17_if.slave bus
);
    localparam int N = DW + FRAC;
`ifdef DIV_ROUND_EN
    localparam int ITER = N + 1;
`else
    localparam int ITER = N;
`endif
    localparam int CW = $clog2(ITER + 1);
    localparam int MW = ITER + 1;

    localparam logic [DW-1:0] ONE_D   = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] SAT_POS = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_NEG = {1'b1, {(DW-1){1'b0}}};
    localparam logic [MW-1:0] POS_LIM = MW'((1 << (DW - 1)) - 1);
    localparam logic [MW-1:0] NEG_LIM = MW'(1 << (DW - 1));

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [ITER-1:0] num;
    logic [ITER-1:0] quo;
    logic [TW-1:0]   rem;
    logic [TW-1:0]   dvs;
    logic            neg;
    logic            dz;

    logic [DW-1:0]   dend_abs;
    logic [TW-1:0]   dvs_abs;
    logic [TW:0]     trial;
    logic            ge;
    logic [TW-1:0]   rem_nxt;
    logic [MW-1:0]   mag;
    logic [DW-1:0]   res;
    logic            res_sat;

    assign bus.in_ready = (state == IDLE);

    // Magnitudes are unsigned, so the most negative inputs (-65536, -128) fit without overflow.
    assign dend_abs = bus.in_17bit[DW-1] ? (~bus.in_17bit + ONE_D) : bus.in_17bit;
    assign dvs_abs  = bus.in_8bit[TW-1]  ? (~bus.in_8bit + {{(TW-1){1'b0}}, 1'b1}) : bus.in_8bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = CALC;
            CALC:    if (cnt == '0)    state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Restoring step: the remainder stays below the divisor, so its low TW bits are exact.
    always_comb begin
        trial   = {rem, num[ITER-1]};
        ge      = (trial >= {1'b0, dvs});
        rem_nxt = ge ? (trial[TW-1:0] - dvs) : trial[TW-1:0];
    end

`ifdef DIV_ROUND_EN
    assign mag = {2'b00, quo[ITER-1:1]} + {{(MW-1){1'b0}}, quo[0]};
`else
    assign mag = {1'b0, quo};
`endif

    // A zero divisor has a clear sign bit, so neg then carries the dividend sign alone.
    always_comb begin
        res     = '0;
        res_sat = 1'b0;
        if (dz) begin
            res     = neg ? SAT_NEG : SAT_POS;
            res_sat = 1'b1;
        end else if (!neg && (mag > POS_LIM)) begin
            res     = SAT_POS;
            res_sat = 1'b1;
        end else if (neg && (mag > NEG_LIM)) begin
            res     = SAT_NEG;
            res_sat = 1'b1;
        end else begin
            res = neg ? (~mag[DW-1:0] + ONE_D) : mag[DW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            num           <= '0;
            quo           <= '0;
            rem           <= '0;
            dvs           <= '0;
            neg           <= 1'b0;
            dz            <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out       <= '0;
            bus.sat       <= 1'b0;
            bus.div_err   <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        neg <= bus.in_17bit[DW-1] ^ bus.in_8bit[TW-1];
                        dz  <= (bus.in_8bit == '0);
                        dvs <= dvs_abs;
                        num <= {dend_abs, {(ITER-DW){1'b0}}};
                        quo <= '0;
                        rem <= '0;
                        cnt <= CW'(ITER - 1);
                    end
                end
                CALC: begin
                    num <= {num[ITER-2:0], 1'b0};
                    quo <= {quo[ITER-2:0], ge};
                    rem <= rem_nxt;
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
                FIX: begin
                    bus.out_valid <= 1'b1;
                    bus.out       <= res;
                    bus.sat       <= res_sat;
                    bus.div_err   <= dz;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fix_div17.sv
// tb/tb_fix_div17.sv - directed vector bench for fix_div17
module tb_fix_div17;
    localparam int DW = 17;
    localparam int TW = 8;
`ifdef DIV_ROUND_EN
    localparam int            LAT   = 26;
    localparam logic [DW-1:0] R1000 = 17'd1008;
    localparam logic [DW-1:0] R5    = 17'd7;
`else
    localparam int            LAT   = 25;
    localparam logic [DW-1:0] R1000 = 17'd1007;
    localparam logic [DW-1:0] R5    = 17'd6;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fix_div17_if #(.DW(DW), .TW(TW)) bus ();

    fix_div17 #(.DW(DW), .TW(TW), .FRAC(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [DW-1:0] a;
        logic [TW-1:0] b;
        logic [DW-1:0] o;
        logic          s;
        logic          e;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    task automatic run_op(input logic [DW-1:0] a, input logic [TW-1:0] b,
                          output logic [DW-1:0] o, output logic s, output logic e,
                          output int lat, output logic busy_ok);
        @(negedge clk);
        bus.in_17bit = a;
        bus.in_8bit  = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = k;
                break;
            end
            if (bus.in_ready) busy_ok = 1'b0;
        end
        o = bus.out;
        s = bus.sat;
        e = bus.div_err;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] o;
        logic          s, e, busy_ok;
        int            lat, edges, pulses;

        vecs[0]  = '{17'h00400, 8'h40, 17'h00800, 1'b0, 1'b0};
        vecs[1]  = '{17'h00400, 8'hC0, 17'h1F800, 1'b0, 1'b0};
        vecs[2]  = '{17'h1FC00, 8'hC0, 17'h00800, 1'b0, 1'b0};
        vecs[3]  = '{17'h10000, 8'h80, 17'h0FFFF, 1'b1, 1'b0};
        vecs[4]  = '{17'h003E8, 8'h7F, R1000,     1'b0, 1'b0};
        vecs[5]  = '{17'h0FFFF, 8'h01, 17'h0FFFF, 1'b1, 1'b0};
        vecs[6]  = '{17'h1FFFB, 8'h00, 17'h10000, 1'b1, 1'b1};
        vecs[7]  = '{17'h00000, 8'h00, 17'h0FFFF, 1'b1, 1'b1};
        vecs[8]  = '{17'h18000, 8'h40, 17'h10000, 1'b0, 1'b0};
        vecs[9]  = '{17'h08000, 8'h40, 17'h0FFFF, 1'b1, 1'b0};
        vecs[10] = '{17'h07FFF, 8'h40, 17'h0FFFE, 1'b0, 1'b0};
        vecs[11] = '{17'h1FFFF, 8'h7F, 17'h1FFFF, 1'b0, 1'b0};
        vecs[12] = '{17'h00000, 8'hC0, 17'h00000, 1'b0, 1'b0};
        vecs[13] = '{17'h00005, 8'h60, R5,        1'b0, 1'b0};
        vecs[14] = '{17'h10000, 8'h7F, 17'h10000, 1'b1, 1'b0};
        vecs[15] = '{17'h00123, 8'h80, 17'h1FEDD, 1'b0, 1'b0};
        vecs[16] = '{17'h0FFFF, 8'h00, 17'h0FFFF, 1'b1, 1'b1};

        bus.in_valid = 1'b0;
        bus.in_17bit = '0;
        bus.in_8bit  = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out", {15'd0, bus.out}, 32'd0);
        chk("rst_sat", {31'd0, bus.sat}, 32'd0);
        chk("rst_div_err", {31'd0, bus.div_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            run_op(vecs[i].a, vecs[i].b, o, s, e, lat, busy_ok);
            chk($sformatf("v%0d_lat", i), lat, LAT);
            chk($sformatf("v%0d_out", i), {15'd0, o}, {15'd0, vecs[i].o});
            chk($sformatf("v%0d_sat", i), {31'd0, s}, {31'd0, vecs[i].s});
            chk($sformatf("v%0d_div_err", i), {31'd0, e}, {31'd0, vecs[i].e});
            chk($sformatf("v%0d_busy_ready", i), {31'd0, busy_ok}, 32'd1);
            chk($sformatf("v%0d_ready_with_valid", i), {31'd0, bus.in_ready}, 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid_pulse", i), {31'd0, bus.out_valid}, 32'd0);
            chk($sformatf("v%0d_out_held", i), {15'd0, bus.out}, {15'd0, vecs[i].o});
        end

        // in_valid held high; operands change mid-operation and are picked up only once idle
        @(negedge clk);
        bus.in_17bit = 17'h00400;
        bus.in_8bit  = 8'h40;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        edges = 0;
        repeat (5) @(posedge clk);
        #1;
        edges = 5;
        bus.in_8bit = 8'hC0;
        while (edges < 80) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.out_valid) break;
        end
        chk("busy_first_edge", edges, LAT);
        chk("busy_first_out", {15'd0, bus.out}, 32'h00800);
        @(posedge clk);
        #1;
        edges++;
        chk("busy_second_accept_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("busy_hold_out", {15'd0, bus.out}, 32'h00800);
        while (edges < 120) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.out_valid) break;
        end
        bus.in_valid = 1'b0;
        chk("busy_second_edge", edges, 2 * LAT + 1);
        chk("busy_second_out", {15'd0, bus.out}, 32'h1F800);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        bus.in_17bit = 17'h07FFF;
        bus.in_8bit  = 8'h40;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", {15'd0, bus.out}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_sat", {31'd0, bus.sat}, 32'd0);
        chk("mid_rst_div_err", {31'd0, bus.div_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) pulses++;
        end
        chk("post_rst_no_pulse", pulses, 0);
        chk("post_rst_ready", {31'd0, bus.in_ready}, 32'd1);
        run_op(17'h1FC00, 8'hC0, o, s, e, lat, busy_ok);
        chk("post_rst_lat", lat, LAT);
        chk("post_rst_out", {15'd0, o}, 32'h00800);
        chk("post_rst_sat", {31'd0, s}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fix_div17.md
# fix_div17

Sequential signed fixed-point divider: the inverse of the butterfly's 17-bit × 8-bit twiddle multiply. It takes a 17-bit two's-complement sample and an 8-bit two's-complement Q1.7 factor and returns the 17-bit quotient (sample ÷ factor, re-scaled by 2^7). It is used on the IFFT / de-normalisation path to undo a twiddle scaling. It computes one quotient bit per clock with a valid/ready handshake on each side.

## Interface
- DW, 17: data width of dividend and quotient.
- TW, 8: divisor width.
- FRAC, 7: divisor fraction bits. Iteration count is N = DW + FRAC (24 at defaults).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands present.
- in_ready  out  1  divider idle. Operands are accepted on an edge where in_valid && in_ready.
- in_17bit  in  DW  dividend, two's complement.
- in_8bit  in  TW  divisor, two's complement Q1.7.
- out_valid  out  1  one-cycle pulse: out, sat and div_err are new.
- out  out  DW  quotient, two's complement, held until the next result.
- sat  out  1  result was saturated. Valid with out_valid.
- div_err  out  1  divisor was zero. Valid with out_valid.

## Operation
- FSM states:
  - IDLE: in_ready=1. On accept, go to CALC.
  - CALC: N edges, then go to FIX.
  - FIX: one edge, then go to IDLE.
- On accept, the following are registered:
  - neg = in_17bit[DW-1] ^ in_8bit[TW-1].
  - |in_17bit|, unsigned DW bits. -65536 gives 65536.
  - |in_8bit|, unsigned TW bits. -128 gives 128.
  - Numerator = |dividend| << FRAC (N bits). Bit counter = N-1.
- CALC performs a restoring division, one quotient bit per edge, MSB first:
  - Remainder (TW+1 bits) = {rem, next numerator bit}.
  - If the remainder ≥ |divisor|: subtract and shift in 1. Otherwise shift in 0.
- Truncation is toward zero: magnitude quotient, then sign applied.
- FIX stage:
  - Positive result: if magnitude > 2^(DW-1)-1, out = 0x0FFFF and sat=1.
  - Negative result: if magnitude > 2^(DW-1), out = 0x10000 and sat=1.
  - Otherwise out = neg ? -mag : mag.
  - A zero quotient is never negated to a nonzero value; -0 gives 0.
- Divisor == 0:
  - The CALC result is ignored and div_err=1, sat=1.
  - out = 0x10000 if the dividend is negative, else 0x0FFFF.
  - A zero dividend with a zero divisor gives 0x0FFFF, div_err=1.
- in_valid while busy is ignored. No operands are queued.
- Async reset at any time:
  - State returns to IDLE and the bit counter is cleared.
  - in_ready=1, out_valid=0, out=0, sat=0, div_err=0.
  - An in-flight result is discarded.

## Timing
- Accept edge = E0. CALC occupies edges E1..E24. FIX registers outputs at E25.
- out_valid is high for exactly the cycle after E25.
- in_ready is low from E0 until E25 and high again together with out_valid.
- A new accept is possible at E26, so the throughput is one operation per 26 clocks.
- Latency is fixed at 25 edges regardless of operands, including the divide-by-zero case.
- The outputs out, sat and div_err change only at a FIX edge or at reset.

## Configuration
- DIV_ROUND_EN defined:
  - CALC runs N+1 iterations to produce one extra fractional quotient bit.
  - The magnitude is rounded half away from zero by adding that bit and then dropping it.
  - Saturation is checked after rounding.
  - Latency is 26 edges: FIX at E26, next accept at E27.
- DIV_ROUND_EN undefined: truncation toward zero and the timing stated above.

## Test plan
- Basic positive case: 0x00400 ÷ 0x40 (0.5) gives out=0x00800 at E25, sat=0, div_err=0.
  - in_ready is low during E1..E24.
- Sign handling:
  - 0x00400 ÷ 0xC0 (-0.5) gives 0x1F800.
  - 0x1FC00 ÷ 0xC0 gives 0x00800.
  - 0x10000 ÷ 0x80 (-1.0) gives 0x0FFFF with sat=1.
- Rounding: 1000 ÷ 0x7F.
  - Macro off: out=1007.
  - Macro on: out=1008 with out_valid one cycle later.
- Saturation and divide-by-zero:
  - 0x0FFFF ÷ 0x01 gives 0x0FFFF, sat=1.
  - 0x1FFFB (-5) ÷ 0x00 gives 0x10000, div_err=1, sat=1.
- Busy input: in_valid held high with operands changed at E5 gives no effect on the result.
  - The second operand is accepted at E26 and its result appears at E51.
- Reset mid-op: rst_n low at E10.
  - Outputs clear immediately, asynchronously.
  - After release: in_ready=1, no out_valid pulse, and the next operation is correct.
